mc_ctrl_g7: RTL and testbench

Multicycle control FSM for the g7 RISC-V core. Sequences the shared datapath (PC, instruction register, register file, unified memory port and the g7 ALU) one instruction at a time. Drives ALU operand selects and the 4-bit `ALUControl` code, and stalls on a memory ready handshake. Sits beside the datapath; one instance per core.

---
 rtl/mc_ctrl_g7_pkg.sv | 43 ++++
 rtl/mc_ctrl_g7_alu_dec.sv | 27 ++
 rtl/mc_ctrl_g7.sv | 131 +++++++++++++
 tb/tb_mc_ctrl_g7.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_g7_pkg.sv
// rtl/mc_ctrl_g7_pkg.sv - shared encodings for the g7 multicycle control path
package mc_ctrl_g7_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

endpackage

// File: rtl/mc_ctrl_g7_alu_dec.sv
// rtl/mc_ctrl_g7_alu_dec.sv - funct3/funct7b5 to ALUControl with unsupported-op flag
import mc_ctrl_g7_pkg::*;

module alu_dec_g7 (
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct3)
            3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111: alu_control = ALU_AND;
            3'b110: alu_control = ALU_OR;
            3'b101: begin
                if (!funct7b5) alu_control = ALU_SRL;
                else           illegal     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_g7.sv
// rtl/mc_ctrl_g7.sv - multicycle control FSM sequencing the shared g7 datapath
import mc_ctrl_g7_pkg::*;

module mc_ctrl_g7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       illegal_instr
);

    state_t     state_q, state_d;
    logic       pc_write, mem_write, ir_write, reg_write, illegal;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    alu_dec_g7 u_alu_dec (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (state_q == S_EXECR),
        .alu_control (dec_alu),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                ALUControl = dec_alu;
                // Unsupported ALU op abandons the instruction without writeback
                illegal    = dec_illegal;
                state_d    = dec_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = ALU_SUB;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by reset itself so they drop in the cycle reset asserts
    assign PCWrite       = pc_write  & rst_n;
    assign MemWrite      = mem_write & rst_n;
    assign IRWrite       = ir_write  & rst_n;
    assign RegWrite      = reg_write & rst_n;
    assign illegal_instr = illegal   & rst_n;

endmodule

// File: tb/tb_mc_ctrl_g7.sv
// tb/tb_mc_ctrl_g7.sv - scoreboard bench for mc_ctrl_g7 with directed instruction vectors
import mc_ctrl_g7_pkg::*;

module tb_mc_ctrl_g7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;

    mc_ctrl_g7 dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal}
    function automatic logic [15:0] mk(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [3:0] alu, logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, ill};
    endfunction

    function automatic logic [15:0] e_fetch(logic mr);
        return mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, ALU_ADD, 0);
    endfunction
    function automatic logic [15:0] e_decode(logic ill);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ALU_ADD, ill);
    endfunction
    function automatic logic [15:0] e_execr(logic [3:0] alu, logic ill);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, ill);
    endfunction
    function automatic logic [15:0] e_execi(logic [3:0] alu, logic ill);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, ill);
    endfunction
    function automatic logic [15:0] e_beq(logic z);
        return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SUB, 0);
    endfunction

    logic [15:0] E_RESET, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE, E_ALUWB, E_JAL;

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show
    task automatic step(logic rst, logic [6:0] opc, logic [2:0] f3, logic b5,
                        logic z, logic mr, logic [15:0] e, string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = opc;
        funct3    = f3;
        funct7b5  = b5;
        zero      = z;
        mem_ready = mr;
        x.v       = e;
        x.name    = name;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [15:0] act;
            x   = exp_q.pop_front();
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, illegal_instr};
            n_cmp++;
            if (act !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", x.name, act, x.v);
            end
        end
    end

    initial begin
        E_RESET    = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ALU_ADD, 0);
        E_MEMADR   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 0);
        E_MEMREAD  = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0);
        E_MEMWB    = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ALU_ADD, 0);
        E_MEMWRITE = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0);
        E_ALUWB    = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ALU_ADD, 0);
        E_JAL      = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ALU_ADD, 0);

        step(0, OP_LW, 3'b010, 0, 0, 1, E_RESET, "reset_mr1");
        step(0, OP_LW, 3'b010, 0, 0, 0, E_RESET, "reset_mr0");
        step(1, OP_LW, 3'b010, 0, 0, 0, e_fetch(0), "fetch_stall");

        // lw with two wait cycles in MEMREAD
        step(1, OP_LW, 3'b010, 0, 0, 1, e_fetch(1), "lw_fetch");
        step(1, OP_LW, 3'b010, 0, 0, 1, e_decode(0), "lw_decode");
        step(1, OP_LW, 3'b010, 0, 0, 1, E_MEMADR, "lw_memadr");
        step(1, OP_LW, 3'b010, 0, 0, 0, E_MEMREAD, "lw_memread_w1");
        step(1, OP_LW, 3'b010, 0, 0, 0, E_MEMREAD, "lw_memread_w2");
        step(1, OP_LW, 3'b010, 0, 0, 1, E_MEMREAD, "lw_memread_go");
        step(1, OP_LW, 3'b010, 0, 0, 1, E_MEMWB, "lw_memwb");

        // beq taken then not taken; mem_ready outside access states is ignored
        step(1, OP_BEQ, 3'b000, 0, 1, 1, e_fetch(1), "beq1_fetch");
        step(1, OP_BEQ, 3'b000, 0, 1, 0, e_decode(0), "beq1_decode");
        step(1, OP_BEQ, 3'b000, 0, 1, 0, e_beq(1), "beq1_taken");
        step(1, OP_BEQ, 3'b000, 0, 0, 1, e_fetch(1), "beq0_fetch");
        step(1, OP_BEQ, 3'b000, 0, 0, 1, e_decode(0), "beq0_decode");
        step(1, OP_BEQ, 3'b000, 0, 0, 1, e_beq(0), "beq0_not_taken");

        step(1, OP_RTYPE, 3'b000, 1, 0, 1, e_fetch(1), "sub_fetch");
        step(1, OP_RTYPE, 3'b000, 1, 0, 1, e_decode(0), "sub_decode");
        step(1, OP_RTYPE, 3'b000, 1, 0, 1, e_execr(ALU_SUB, 0), "sub_exec");
        step(1, OP_RTYPE, 3'b000, 1, 0, 1, E_ALUWB, "sub_wb");

        step(1, OP_IALU, 3'b000, 1, 0, 1, e_fetch(1), "addi_fetch");
        step(1, OP_IALU, 3'b000, 1, 0, 1, e_decode(0), "addi_decode");
        step(1, OP_IALU, 3'b000, 1, 0, 1, e_execi(ALU_ADD, 0), "addi_exec");
        step(1, OP_IALU, 3'b000, 1, 0, 1, E_ALUWB, "addi_wb");

        step(1, OP_IALU, 3'b101, 0, 0, 1, e_fetch(1), "srli_fetch");
        step(1, OP_IALU, 3'b101, 0, 0, 1, e_decode(0), "srli_decode");
        step(1, OP_IALU, 3'b101, 0, 0, 1, e_execi(ALU_SRL, 0), "srli_exec");
        step(1, OP_IALU, 3'b101, 0, 0, 1, E_ALUWB, "srli_wb");

        step(1, OP_RTYPE, 3'b111, 0, 0, 1, e_fetch(1), "and_fetch");
        step(1, OP_RTYPE, 3'b111, 0, 0, 1, e_decode(0), "and_decode");
        step(1, OP_RTYPE, 3'b111, 0, 0, 1, e_execr(ALU_AND, 0), "and_exec");
        step(1, OP_RTYPE, 3'b111, 0, 0, 1, E_ALUWB, "and_wb");

        step(1, OP_IALU, 3'b110, 0, 0, 1, e_fetch(1), "ori_fetch");
        step(1, OP_IALU, 3'b110, 0, 0, 1, e_decode(0), "ori_decode");
        step(1, OP_IALU, 3'b110, 0, 0, 1, e_execi(ALU_OR, 0), "ori_exec");
        step(1, OP_IALU, 3'b110, 0, 0, 1, E_ALUWB, "ori_wb");

        // sll is unsupported: flagged in EXECUTER, writeback skipped
        step(1, OP_RTYPE, 3'b001, 0, 0, 1, e_fetch(1), "sll_fetch");
        step(1, OP_RTYPE, 3'b001, 0, 0, 1, e_decode(0), "sll_decode");
        step(1, OP_RTYPE, 3'b001, 0, 0, 1, e_execr(ALU_ADD, 1), "sll_exec_illegal");

        // lui is unsupported: flagged in DECODE, straight back to FETCH
        step(1, 7'b0110111, 3'b000, 0, 0, 1, e_fetch(1), "lui_fetch");
        step(1, 7'b0110111, 3'b000, 0, 0, 1, e_decode(1), "lui_decode_illegal");

        step(1, OP_JAL, 3'b000, 0, 0, 1, e_fetch(1), "jal_fetch");
        step(1, OP_JAL, 3'b000, 0, 0, 1, e_decode(0), "jal_decode");
        step(1, OP_JAL, 3'b000, 0, 0, 1, E_JAL, "jal_pcwrite");
        step(1, OP_JAL, 3'b000, 0, 0, 1, E_ALUWB, "jal_wb");

        step(1, OP_SW, 3'b010, 0, 0, 1, e_fetch(1), "sw_fetch");
        step(1, OP_SW, 3'b010, 0, 0, 1, e_decode(0), "sw_decode");
        step(1, OP_SW, 3'b010, 0, 0, 1, E_MEMADR, "sw_memadr");
        step(1, OP_SW, 3'b010, 0, 0, 1, E_MEMWRITE, "sw_memwrite");

        // sw interrupted by reset while the write is stalled
        step(1, OP_SW, 3'b010, 0, 0, 1, e_fetch(1), "swr_fetch");
        step(1, OP_SW, 3'b010, 0, 0, 1, e_decode(0), "swr_decode");
        step(1, OP_SW, 3'b010, 0, 0, 1, E_MEMADR, "swr_memadr");
        step(1, OP_SW, 3'b010, 0, 0, 0, E_MEMWRITE, "swr_memwrite_wait");
        step(0, OP_SW, 3'b010, 0, 0, 0, E_RESET, "swr_reset_drops_write");
        step(1, OP_SW, 3'b010, 0, 0, 0, e_fetch(0), "swr_after_reset_wait");
        step(1, OP_SW, 3'b010, 0, 0, 1, e_fetch(1), "swr_after_reset_go");
        step(1, OP_SW, 3'b010, 0, 0, 1, e_decode(0), "swr_redecode");

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
